otter_lsu: RTL and testbench
============================

Name: otter_lsu

Overview:
- Load/store unit between the OTTER CPU memory stage and data port 2 of the OTTER byte memory.
- Splits any CPU load/store, including word-crossing misaligned ones, into word-aligned full-word accesses only (MEM_SIZE=2, address[1:0]=0).
- Sub-word and misaligned stores are done by read-modify-write.
- Returns sliced, sign- or zero-extended load data with a one-cycle DONE pulse.

Parameters:
- MEM_BYTES, 65536, RAM size in bytes; word addresses at or above this are out of bounds.
- IO_BASE, 32'h11000000, addresses at or above this are MMIO and passed through unsplit.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- LSU_REQ  in  1  request strobe, sampled only when LSU_BUSY=0
- LSU_WE  in  1  1=store, 0=load
- LSU_ADDR  in  32  byte address
- LSU_WDATA  in  32  store data, right-aligned
- LSU_SIZE  in  2  0=byte, 1=half, 2=word, 3=illegal
- LSU_SIGN  in  1  1=zero-extend (lbu/lhu), 0=sign-extend
- LSU_BUSY  out  1  high in every state except IDLE
- LSU_DONE  out  1  one-cycle completion pulse
- LSU_RDATA  out  32  load result, held until next DONE
- LSU_ERR  out  1  valid with DONE
- MEM_ADDR2  out  32  memory address
- MEM_DIN2  out  32  memory write data
- MEM_WRITE2  out  1  write strobe
- MEM_READ2  out  1  read strobe
- MEM_SIZE  out  2  always 2
- MEM_SIGN  out  1  always 0
- MEM_DOUT2  in  32  memory read data; valid the cycle after MEM_READ2 while the address is held word-aligned

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except MEM_SIZE=2; internal buffers 0.
- Reset mid-operation aborts at once; a spanning store may leave only the low word written. This is accepted.
- Acceptance: LSU_REQ=1 in IDLE latches WE/ADDR/WDATA/SIZE/SIGN. REQ while BUSY is ignored.
- Address decode:
  - off = ADDR[1:0]; nb = 1/2/4 by SIZE.
  - lo = ADDR & ~3; hi = lo + 4.
  - span = (off + nb > 4).
  - io = ADDR >= IO_BASE.
- Error case (SIZE=3, or !io and (span ? hi : lo) >= MEM_BYTES):
  - go straight to RESP with LSU_ERR=1.
  - no MEM strobe; RDATA unchanged.
- States and transitions:
  - IDLE: on accept → WR_LO if (store and (io or (SIZE=2 and off=0))); else RD_LO.
  - RD_LO: MEM_READ2=1, MEM_ADDR2 = io ? ADDR : lo. → RD_HI if span, else RD_END.
  - RD_HI: capture MEM_DOUT2 → lo_buf; MEM_READ2=1, MEM_ADDR2=hi. → RD_END.
  - RD_END: MEM_ADDR2 held; capture MEM_DOUT2 → hi_buf if span, else lo_buf. Load → RESP; store → WR_LO.
  - WR_LO: MEM_WRITE2=1. Address is io ? ADDR : lo. Data is io ? WDATA : merged low word. → WR_HI if span, else RESP.
  - WR_HI: MEM_WRITE2=1, MEM_ADDR2=hi, MEM_DIN2 = merged high word. → RESP.
  - RESP: LSU_DONE=1; for loads, LSU_RDATA registered the same edge RESP is entered. → IDLE.
- Load slicing (little-endian, RAM only):
  - v = {hi_buf, lo_buf} >> (8*off); take the low nb bytes.
  - Extend to 32 bits: sign-extend when LSU_SIGN=0, zero-extend when LSU_SIGN=1.
  - IO loads return MEM_DOUT2 raw, with no slicing.
- Store merge:
  - mask64 = byte-mask(nb) << off.
  - data64 = {32'b0, WDATA} << (8*off).
  - new = (old & ~mask64) | (data64 & mask64), where old = {hi_buf, lo_buf}.
- Latency, accept edge to DONE cycle, counted in cycles:
  - aligned or non-spanning load: 3
  - spanning load: 4
  - aligned sw or IO store: 2
  - non-spanning sub-word/misaligned store: 4
  - spanning store: 6
  - error: 1
- Strobes: only one of MEM_READ2/MEM_WRITE2 is high in any cycle; both are 0 in IDLE and RESP.
- Back-to-back: next REQ is accepted in the IDLE cycle after RESP.

Test Plan:
- mem[0x100]=0x8899AABB; load SIZE=0 SIGN=0 ADDR=0x103 → RDATA=0xFFFFFF88, DONE 3 cycles after accept, ERR=0. Same with SIGN=1 → 0x00000088.
- mem[0x100]=0x44332211, mem[0x104]=0x88776655; lw ADDR=0x102 → RDATA=0x66554433, DONE at cycle 4; reads at 0x100 then 0x104.
- Same preload; sh WDATA=0x0000BEEF ADDR=0x103 → mem[0x100]=0xEF332211, mem[0x104]=0x887766BE; exactly two MEM_WRITE2 cycles; DONE at cycle 6.
- sw 0xDEADBEEF ADDR=0x11000000 → one MEM_WRITE2 cycle at 0x11000000 with DIN=0xDEADBEEF; no MEM_READ2; DONE at cycle 2.
- SIZE=3 load, and lw ADDR=0x0000FFFE → DONE+ERR after 1 cycle; no MEM strobes; RDATA unchanged.
- Assert RST_N=0 during WR_HI of a spanning sw → outputs 0 and BUSY=0 immediately. After release, lw 0x100 → 0xEF332211, with mem[0x104] not rewritten.

Source files
------------

// File: rtl/otter_lsu_if.sv
// CPU-side request/response and data-port-2 memory signals of the OTTER load/store unit.
interface otter_lsu_if;
  logic        LSU_REQ;
  logic        LSU_WE;
  logic [31:0] LSU_ADDR;
  logic [31:0] LSU_WDATA;
  logic [1:0]  LSU_SIZE;
  logic        LSU_SIGN;
  logic        LSU_BUSY;
  logic        LSU_DONE;
  logic [31:0] LSU_RDATA;
  logic        LSU_ERR;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport slave (
    input  LSU_REQ, LSU_WE, LSU_ADDR, LSU_WDATA, LSU_SIZE, LSU_SIGN, MEM_DOUT2,
    output LSU_BUSY, LSU_DONE, LSU_RDATA, LSU_ERR,
           MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

  modport master (
    output LSU_REQ, LSU_WE, LSU_ADDR, LSU_WDATA, LSU_SIZE, LSU_SIGN, MEM_DOUT2,
    input  LSU_BUSY, LSU_DONE, LSU_RDATA, LSU_ERR,
           MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );
endinterface

// File: rtl/otter_lsu.sv
// OTTER load/store unit: breaks any load/store into word-aligned full-word memory
// accesses, doing read-modify-write for sub-word and misaligned stores.
module otter_lsu #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] IO_BASE   = 32'h1100_0000
) (
  input logic        CLK,
  input logic        RST_N,
  otter_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    RD_END = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    RESP   = 3'd6
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] lo_buf_q, lo_buf_d, hi_buf_q, hi_buf_d;
  logic        err_q, err_d;
  logic        accept;

  logic [1:0]  off;
  logic [2:0]  nb;
  logic [4:0]  sh;
  logic [31:0] lo_addr, hi_addr;
  logic        io, span, bad;

  logic [63:0] old_w, shifted, mask_base, mask, data_w, merged;
  logic [31:0] slice, load_val;

  logic        busy_n, done_n, err_n, rd_n, wr_n;
  logic [31:0] rdata_n, addr_n, din_n;

  assign accept = (state_q == IDLE) && bus.LSU_REQ;

  // Request fields as they will be after this edge; decode runs off these so the
  // accept cycle can already choose its first memory access.
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.we    = bus.LSU_WE;
      req_d.addr  = bus.LSU_ADDR;
      req_d.wdata = bus.LSU_WDATA;
      req_d.size  = bus.LSU_SIZE;
      req_d.sign  = bus.LSU_SIGN;
    end
  end

  always_comb begin
    case (req_d.size)
      2'd0:    nb = 3'd1;
      2'd1:    nb = 3'd2;
      default: nb = 3'd4;
    endcase
  end

  assign off     = req_d.addr[1:0];
  assign sh      = {off, 3'b000};
  assign lo_addr = {req_d.addr[31:2], 2'b00};
  assign hi_addr = lo_addr + 32'd4;
  assign io      = (req_d.addr >= IO_BASE);
  assign span    = !io && ((3'(off) + nb) > 3'd4);
  assign bad     = (req_d.size == 2'd3) ||
                   (!io && ((span ? hi_addr : lo_addr) >= 32'(MEM_BYTES)));

  // State and working registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      req_q    <= '0;
      lo_buf_q <= '0;
      hi_buf_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      lo_buf_q <= lo_buf_d;
      hi_buf_q <= hi_buf_d;
      err_q    <= err_d;
    end
  end

  // Next state and buffer capture
  always_comb begin
    state_d  = state_q;
    lo_buf_d = lo_buf_q;
    hi_buf_d = hi_buf_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = bad;
          if (bad)
            state_d = RESP;
          else if (req_d.we && (io || (req_d.size == 2'd2 && off == 2'd0)))
            state_d = WR_LO;
          else
            state_d = RD_LO;
        end
      end
      RD_LO:  state_d = span ? RD_HI : RD_END;
      RD_HI: begin
        lo_buf_d = bus.MEM_DOUT2;
        state_d  = RD_END;
      end
      RD_END: begin
        if (span) hi_buf_d = bus.MEM_DOUT2;
        else      lo_buf_d = bus.MEM_DOUT2;
        state_d = req_d.we ? WR_LO : RESP;
      end
      WR_LO:   state_d = span ? WR_HI : RESP;
      WR_HI:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian slice/extend for loads and byte-lane merge for stores
  assign old_w   = {hi_buf_d, lo_buf_d};
  assign shifted = old_w >> sh;

  always_comb begin
    case (req_d.size)
      2'd0:    slice = req_d.sign ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'd1:    slice = req_d.sign ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: slice = shifted[31:0];
    endcase
    case (req_d.size)
      2'd0:    mask_base = 64'h0000_0000_0000_00FF;
      2'd1:    mask_base = 64'h0000_0000_0000_FFFF;
      default: mask_base = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  assign load_val = io ? bus.MEM_DOUT2 : slice;
  assign mask     = mask_base << sh;
  assign data_w   = {32'd0, req_d.wdata} << sh;
  assign merged   = (old_w & ~mask) | (data_w & mask);

  // Output values for the state being entered
  always_comb begin
    busy_n  = (state_d != IDLE);
    done_n  = (state_d == RESP);
    err_n   = (state_d == RESP) && err_d;
    rdata_n = bus.LSU_RDATA;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = 32'd0;
    din_n   = 32'd0;
    if (state_q == RD_END && state_d == RESP)
      rdata_n = load_val;
    case (state_d)
      RD_LO: begin
        rd_n   = 1'b1;
        addr_n = io ? req_d.addr : lo_addr;
      end
      RD_HI: begin
        rd_n   = 1'b1;
        addr_n = hi_addr;
      end
      RD_END: addr_n = bus.MEM_ADDR2;
      WR_LO: begin
        wr_n   = 1'b1;
        addr_n = io ? req_d.addr : lo_addr;
        din_n  = io ? req_d.wdata : merged[31:0];
      end
      WR_HI: begin
        wr_n   = 1'b1;
        addr_n = hi_addr;
        din_n  = merged[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.LSU_BUSY   <= 1'b0;
      bus.LSU_DONE   <= 1'b0;
      bus.LSU_ERR    <= 1'b0;
      bus.LSU_RDATA  <= 32'd0;
      bus.MEM_READ2  <= 1'b0;
      bus.MEM_WRITE2 <= 1'b0;
      bus.MEM_ADDR2  <= 32'd0;
      bus.MEM_DIN2   <= 32'd0;
    end else begin
      bus.LSU_BUSY   <= busy_n;
      bus.LSU_DONE   <= done_n;
      bus.LSU_ERR    <= err_n;
      bus.LSU_RDATA  <= rdata_n;
      bus.MEM_READ2  <= rd_n;
      bus.MEM_WRITE2 <= wr_n;
      bus.MEM_ADDR2  <= addr_n;
      bus.MEM_DIN2   <= din_n;
    end
  end

  assign bus.MEM_SIZE = 2'd2;
  assign bus.MEM_SIGN = 1'b0;

endmodule

// File: tb/tb_otter_lsu.sv
// Bench for otter_lsu: word memory model on port 2, scoreboard of expected
// load results/latencies, directed scenarios plus a random RAM load/store mix.
module tb_otter_lsu;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;
  localparam logic [31:0] IO_RVAL = 32'hA5A5_0F0F;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  otter_lsu_if bus ();

  otter_lsu #(.MEM_BYTES(65536), .IO_BASE(IO_BASE)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  logic        pl_we = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  // Synchronous-read word memory; preload port used only while the LSU is idle
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus.MEM_WRITE2 && bus.MEM_ADDR2 < IO_BASE) mem[bus.MEM_ADDR2[15:2]] <= bus.MEM_DIN2;
    if (bus.MEM_READ2)
      bus.MEM_DOUT2 <= (bus.MEM_ADDR2 >= IO_BASE) ? IO_RVAL : mem[bus.MEM_ADDR2[15:2]];
  end

  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];
  logic [31:0] last_rd = 32'd0;

  int          n_rd, n_wr;
  logic        both_hi;
  logic [31:0] rd_addrs[$];
  logic [31:0] wr_addrs[$];
  logic [31:0] wr_data[$];

  logic [7:0] rmem [0:255];

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a[15:2]; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Drive one request, observe strobes each cycle until DONE (bounded)
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic sign,
                       output int lat, output logic [31:0] rd, output logic er, output logic got);
    @(negedge clk);
    bus.LSU_REQ = 1'b1; bus.LSU_WE = we; bus.LSU_ADDR = addr;
    bus.LSU_WDATA = wd; bus.LSU_SIZE = size; bus.LSU_SIGN = sign;
    @(posedge clk);
    #1 bus.LSU_REQ = 1'b0;
    n_rd = 0; n_wr = 0; both_hi = 1'b0;
    rd_addrs.delete(); wr_addrs.delete(); wr_data.delete();
    got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (bus.MEM_READ2) begin n_rd++; rd_addrs.push_back(bus.MEM_ADDR2); end
      if (bus.MEM_WRITE2) begin
        n_wr++; wr_addrs.push_back(bus.MEM_ADDR2); wr_data.push_back(bus.MEM_DIN2);
      end
      if (bus.MEM_READ2 && bus.MEM_WRITE2) both_hi = 1'b1;
      if (bus.LSU_DONE) begin
        got = 1'b1; lat = i; rd = bus.LSU_RDATA; er = bus.LSU_ERR;
      end
    end
  endtask

  task automatic test_reset();
    n_chk++; if (bus.LSU_BUSY !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.LSU_BUSY); else n_pass++;
    n_chk++; if (bus.LSU_DONE !== 1'b0) $display("FAIL reset_done: got %b exp 0", bus.LSU_DONE); else n_pass++;
    n_chk++; if (bus.LSU_RDATA !== 32'd0) $display("FAIL reset_rdata: got %h exp 0", bus.LSU_RDATA); else n_pass++;
    n_chk++; if ({bus.MEM_READ2, bus.MEM_WRITE2, bus.LSU_ERR} !== 3'b000)
      $display("FAIL reset_strobes: got %b exp 000", {bus.MEM_READ2, bus.MEM_WRITE2, bus.LSU_ERR}); else n_pass++;
    n_chk++; if (bus.MEM_SIZE !== 2'd2) $display("FAIL reset_memsize: got %0d exp 2", bus.MEM_SIZE); else n_pass++;
    n_chk++; if (bus.MEM_ADDR2 !== 32'd0) $display("FAIL reset_addr: got %h exp 0", bus.MEM_ADDR2); else n_pass++;
  endtask

  task automatic test_byte_load();
    int lat; logic [31:0] rd; logic er, got; exp_t e;
    preload(32'h100, 32'h8899_AABB);
    for (int s = 0; s < 2; s++) begin
      sb.push_back('{rdata: (s == 0) ? 32'hFFFF_FF88 : 32'h0000_0088, err: 1'b0, lat: 3});
      issue(1'b0, 32'h103, 32'd0, 2'd0, s[0], lat, rd, er, got);
      e = sb.pop_front();
      last_rd = e.rdata;
      n_chk++; if (!got) $display("FAIL lb_done: timeout sign=%0d", s); else n_pass++;
      n_chk++; if (rd !== e.rdata) $display("FAIL lb_rdata: sign=%0d got %h exp %h", s, rd, e.rdata); else n_pass++;
      n_chk++; if (lat != e.lat || er !== e.err)
        $display("FAIL lb_lat_err: got lat %0d err %b exp lat %0d err %b", lat, er, e.lat, e.err); else n_pass++;
    end
  endtask

  task automatic test_span_load();
    int lat; logic [31:0] rd; logic er, got; exp_t e;
    preload(32'h100, 32'h4433_2211);
    preload(32'h104, 32'h8877_6655);
    sb.push_back('{rdata: 32'h6655_4433, err: 1'b0, lat: 4});
    issue(1'b0, 32'h102, 32'd0, 2'd2, 1'b0, lat, rd, er, got);
    e = sb.pop_front();
    last_rd = e.rdata;
    n_chk++; if (rd !== e.rdata || !got) $display("FAIL span_lw_rdata: got %h exp %h", rd, e.rdata); else n_pass++;
    n_chk++; if (lat != e.lat) $display("FAIL span_lw_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
    n_chk++; if (n_rd != 2 || n_wr != 0 || rd_addrs[0] !== 32'h100 || rd_addrs[1] !== 32'h104)
      $display("FAIL span_lw_reads: got %0d reads %0d writes exp reads 0x100,0x104", n_rd, n_wr); else n_pass++;
  endtask

  task automatic test_span_store();
    int lat; logic [31:0] rd; logic er, got; exp_t e;
    sb.push_back('{rdata: last_rd, err: 1'b0, lat: 6});
    issue(1'b1, 32'h103, 32'h0000_BEEF, 2'd1, 1'b0, lat, rd, er, got);
    e = sb.pop_front();
    @(negedge clk);
    n_chk++; if (lat != e.lat || !got) $display("FAIL span_sh_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
    n_chk++; if (n_wr != 2 || n_rd != 2) $display("FAIL span_sh_strobes: got %0d writes %0d reads exp 2 2", n_wr, n_rd); else n_pass++;
    n_chk++; if (mem[32'h100 >> 2] !== 32'hEF33_2211) $display("FAIL span_sh_lo: got %h exp ef332211", mem[32'h100 >> 2]); else n_pass++;
    n_chk++; if (mem[32'h104 >> 2] !== 32'h8877_66BE) $display("FAIL span_sh_hi: got %h exp 887766be", mem[32'h104 >> 2]); else n_pass++;
    n_chk++; if (rd !== e.rdata) $display("FAIL span_sh_rdata_held: got %h exp %h", rd, e.rdata); else n_pass++;
  endtask

  task automatic test_io();
    int lat; logic [31:0] rd; logic er, got; exp_t e;
    sb.push_back('{rdata: last_rd, err: 1'b0, lat: 2});
    issue(1'b1, IO_BASE, 32'hDEAD_BEEF, 2'd2, 1'b0, lat, rd, er, got);
    e = sb.pop_front();
    n_chk++; if (lat != e.lat || !got) $display("FAIL io_sw_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
    n_chk++; if (n_wr != 1 || n_rd != 0) $display("FAIL io_sw_strobes: got %0d writes %0d reads exp 1 0", n_wr, n_rd); else n_pass++;
    n_chk++; if (n_wr == 1 && (wr_addrs[0] !== IO_BASE || wr_data[0] !== 32'hDEAD_BEEF))
      $display("FAIL io_sw_bus: got addr %h din %h exp 11000000 deadbeef", wr_addrs[0], wr_data[0]); else n_pass++;
    sb.push_back('{rdata: IO_RVAL, err: 1'b0, lat: 3});
    issue(1'b0, IO_BASE + 32'd6, 32'd0, 2'd0, 1'b0, lat, rd, er, got);
    e = sb.pop_front();
    last_rd = e.rdata;
    n_chk++; if (rd !== e.rdata || lat != e.lat)
      $display("FAIL io_lb_raw: got %h lat %0d exp %h lat %0d", rd, lat, e.rdata, e.lat); else n_pass++;
    n_chk++; if (n_rd != 1 || rd_addrs[0] !== IO_BASE + 32'd6)
      $display("FAIL io_lb_addr: got %0d reads exp 1 at 11000006", n_rd); else n_pass++;
  endtask

  task automatic test_error();
    int lat; logic [31:0] rd; logic er, got; exp_t e;
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h100;      sizes[0] = 2'd3;
    addrs[1] = 32'h0000_FFFE; sizes[1] = 2'd2;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{rdata: last_rd, err: 1'b1, lat: 1});
      issue(1'b0, addrs[k], 32'd0, sizes[k], 1'b0, lat, rd, er, got);
      e = sb.pop_front();
      n_chk++; if (er !== e.err || lat != e.lat || !got)
        $display("FAIL err_resp%0d: got err %b lat %0d exp err 1 lat 1", k, er, lat); else n_pass++;
      n_chk++; if (n_rd != 0 || n_wr != 0) $display("FAIL err_nostrobe%0d: got %0d reads %0d writes exp 0", k, n_rd, n_wr); else n_pass++;
      n_chk++; if (rd !== e.rdata) $display("FAIL err_rdata%0d: got %h exp %h", k, rd, e.rdata); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat, nbytes, off; logic [31:0] rd; logic er, got; exp_t e;
    logic we, sign; logic [1:0] size; logic [31:0] addr, wd, v, val;
    for (int w = 0; w < 64; w++) begin
      v = $urandom();
      preload(32'h200 + 32'(4 * w), v);
      for (int b = 0; b < 4; b++) rmem[w * 4 + b] = v[8 * b +: 8];
    end
    repeat (24) begin
      we = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 2));
      sign = 1'($urandom_range(0, 1));
      addr = 32'h200 + 32'($urandom_range(0, 248));
      wd = $urandom();
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off = int'(addr[1:0]);
      if (!we) begin
        val = '0;
        for (int b = 0; b < nbytes; b++) val[8 * b +: 8] = rmem[addr[7:0] + 8'(b)];
        if (!sign && nbytes == 1) val = {{24{val[7]}}, val[7:0]};
        if (!sign && nbytes == 2) val = {{16{val[15]}}, val[15:0]};
        last_rd = val;
        sb.push_back('{rdata: val, err: 1'b0, lat: (off + nbytes > 4) ? 4 : 3});
      end else begin
        for (int b = 0; b < nbytes; b++) rmem[addr[7:0] + 8'(b)] = wd[8 * b +: 8];
        sb.push_back('{rdata: last_rd, err: 1'b0,
                       lat: (size == 2'd2 && off == 0) ? 2 : (off + nbytes > 4) ? 6 : 4});
      end
      issue(we, addr, wd, size, sign, lat, rd, er, got);
      e = sb.pop_front();
      n_chk++; if (!got || rd !== e.rdata || er !== e.err || lat != e.lat)
        $display("FAIL rand we=%0d sz=%0d a=%h: got %h lat %0d err %b exp %h lat %0d err %b",
                 we, size, addr, rd, lat, er, e.rdata, e.lat, e.err); else n_pass++;
      n_chk++; if (both_hi) $display("FAIL rand_strobe_excl: got read+write together exp never"); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er, got; logic hit; int cyc; exp_t e;
    preload(32'h100, 32'h4433_2211);
    preload(32'h104, 32'h8877_6655);
    @(negedge clk);
    bus.LSU_REQ = 1'b1; bus.LSU_WE = 1'b1; bus.LSU_ADDR = 32'h103;
    bus.LSU_WDATA = 32'h1234_56EF; bus.LSU_SIZE = 2'd2; bus.LSU_SIGN = 1'b0;
    @(posedge clk);
    #1 bus.LSU_REQ = 1'b0;
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 12) begin
      @(negedge clk); cyc++;
      if (bus.MEM_WRITE2 && bus.MEM_ADDR2 == 32'h104) hit = 1'b1;
    end
    n_chk++; if (!hit || cyc != 5) $display("FAIL mid_wr_hi_reached: got hit %b cycle %0d exp 1 5", hit, cyc); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.LSU_BUSY, bus.MEM_WRITE2, bus.MEM_READ2, bus.LSU_DONE} !== 4'b0000 || bus.MEM_DIN2 !== 32'd0)
      $display("FAIL mid_reset_outs: got busy %b wr %b din %h exp 0", bus.LSU_BUSY, bus.MEM_WRITE2, bus.MEM_DIN2); else n_pass++;
    n_chk++; if (bus.MEM_SIZE !== 2'd2) $display("FAIL mid_reset_size: got %0d exp 2", bus.MEM_SIZE); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'd0;
    sb.push_back('{rdata: 32'hEF33_2211, err: 1'b0, lat: 3});
    issue(1'b0, 32'h100, 32'd0, 2'd2, 1'b0, lat, rd, er, got);
    e = sb.pop_front();
    n_chk++; if (rd !== e.rdata || lat != e.lat) $display("FAIL mid_lo_word: got %h lat %0d exp %h lat %0d", rd, lat, e.rdata, e.lat); else n_pass++;
    n_chk++; if (mem[32'h104 >> 2] !== 32'h8877_6655) $display("FAIL mid_hi_untouched: got %h exp 88776655", mem[32'h104 >> 2]); else n_pass++;
  endtask

  initial begin
    bus.LSU_REQ = 1'b0; bus.LSU_WE = 1'b0; bus.LSU_ADDR = '0;
    bus.LSU_WDATA = '0; bus.LSU_SIZE = '0; bus.LSU_SIGN = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_byte_load();
    test_span_load();
    test_span_store();
    test_io();
    test_error();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
